// File: rtl/serial_word_sender_pkg.sv
// serial_pkg: shared state type, default width and bit-ordering helper for serial_word_sender.
package serial_pkg;
   typedef enum logic {IDLE, SEND} send_state_t;
   localparam int DEFAULT_WIDTH = 64;
   function automatic int unsigned bit_index(int unsigned cnt, bit lsb_first, int unsigned width = DEFAULT_WIDTH);
      return lsb_first ? cnt : width - 1 - cnt;
   endfunction
endpackage

// File: rtl/serial_word_sender_if.sv
// serial_word_sender_if: word input and serial output handshakes of serial_word_sender.
interface serial_word_sender_if import serial_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int SEL_W = $clog2(WIDTH)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_bit;
   logic             out_last;
   logic [SEL_W-1:0] out_idx;
   logic             busy;
   modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_bit, out_last, out_idx, busy);
   modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_bit, out_last, out_idx, busy);
endinterface

// File: rtl/serial_word_sender_bit_select.sv
// word_bit_select: WIDTH:1 bit selector; a two-level tree of 8:1 selectors when WIDTH is 64.
module word_bit_select import serial_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int SEL_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] in,
   input  logic [SEL_W-1:0] sel,
   output logic             out
);
   if (WIDTH == 64) begin : g_tree
      logic [7:0] grp;
      for (genvar i = 0; i < 8; i++) begin : g_leaf
         assign grp[i] = in[{3'(i), sel[2:0]}];
      end
      assign out = grp[sel[5:3]];
   end else begin : g_flat
      assign out = in[sel];
   end
endmodule

// File: rtl/serial_word_sender.sv
// serial_word_sender: holds one word and shifts it out one bit per valid/ready beat.
// Define SERIAL_WORD_SENDER_PARITY_EN to append an even-parity beat after each word.
module serial_word_sender import serial_pkg::*; #(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = 1'b1
) (
   input logic clk,
   input logic rst_n,
   serial_word_sender_if.slave bus
);
   localparam int SEL_W = $clog2(WIDTH);
   localparam logic [0:0] S_IDLE = 1'(IDLE);
   localparam logic [0:0] S_SEND = 1'(SEND);
`ifdef SERIAL_WORD_SENDER_PARITY_EN
   localparam int CNT_W = SEL_W + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
   localparam int CNT_W = SEL_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif
   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] data_idx, idx;
   logic             sel_bit, beat_bit, send, last, xfer, accept;
   assign data_idx = SEL_W'(bit_index(32'(cnt_q[SEL_W-1:0]), LSB_FIRST, WIDTH));
   word_bit_select #(.WIDTH(WIDTH)) u_sel (.in(word_q), .sel(data_idx), .out(sel_bit));
`ifdef SERIAL_WORD_SENDER_PARITY_EN
   // Counter value WIDTH is the parity beat; it reports the last data position.
   assign idx      = cnt_q[SEL_W] ? SEL_W'(WIDTH - 1) : data_idx;
   assign beat_bit = cnt_q[SEL_W] ? ^word_q : sel_bit;
`else
   assign idx      = data_idx;
   assign beat_bit = sel_bit;
`endif
   always_comb begin
      send          = state_q == S_SEND;
      last          = send && cnt_q == LAST_CNT;
      xfer          = send && bus.out_ready;
      bus.in_ready  = !send || (last && bus.out_ready);
      accept        = bus.in_valid && bus.in_ready;
      state_d       = accept ? S_SEND : (xfer && last) ? S_IDLE : state_q;
      word_d        = accept ? bus.in_data : word_q;
      cnt_d         = (accept || (xfer && last)) ? '0 : xfer ? cnt_q + 1'b1 : cnt_q;
      bus.out_valid = send;
      bus.busy      = send;
      bus.out_last  = last;
      bus.out_bit   = send && beat_bit;
      bus.out_idx   = send ? idx : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
